nvme_req_arb: RTL and testbench
===============================

NVME_REQ_ARB -- requirements
Module: nvme_req_arb

Interface
REQ-001 Parameter CH, default 2, number of NVMe request channels; CHW = max(1, clog2(CH)).
REQ-002 afu_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 afu_rst  in  1  asynchronous, active-high reset.
REQ-004 i_end_proc  in  1  synchronous abort; all state returns to idle.
REQ-005 i_delay_cnt  in  64  emulated NVMe latency, in cycles, added after each downstream response.
REQ-006 rd_valid[CH], rd_araddr[CH][64]  in  read request per channel; rd_ready[CH]  out  1  request accept.
REQ-007 rd_return_valid[CH]  out  1, rd_rdata[CH]  out  512, rd_return_ready[CH]  in  1  read completion.
REQ-008 wr_valid[CH], wr_awaddr[CH][64], wr_wdata[CH][512], wr_wstrb[CH][64]  in  write request; wr_ready[CH]  out  1.
REQ-009 wr_return_valid[CH]  out  1, wr_return_ready[CH]  in  1  write completion.
REQ-010 o_req_valid out 1, i_req_ready in 1, o_req_is_wr out 1, o_req_addr out 64, o_req_wdata out 512, o_req_wstrb out 64, o_req_ch out CHW  downstream cache request.
REQ-011 i_rsp_valid in 1, o_rsp_ready out 1, i_rsp_rdata in 512  downstream response.
REQ-012 o_done_cnt  out  32  count of completed transactions.

Function
REQ-013 Exactly one transaction outstanding at any time; FSM states IDLE, ISSUE, WAIT_RSP, DELAY, RETURN.
REQ-014 Sources ordered rd0, wr0, rd1, wr1, ... (index 2c for read, 2c+1 for write); round-robin pointer selects the first valid source at or after the pointer, wrapping.
REQ-015 IDLE: when any source is valid, assert that source's ready combinationally for exactly that cycle; latch type, channel, addr, wdata, wstrb, and i_delay_cnt; go to ISSUE.
REQ-016 IDLE with no valid source: all readies 0; stay in IDLE.
REQ-017 ISSUE: o_req_valid=1 with latched fields, held stable; on i_req_ready go to WAIT_RSP.
REQ-018 WAIT_RSP: o_rsp_ready=1; on i_rsp_valid latch i_rsp_rdata (reads only); go to DELAY if latched delay is nonzero, else RETURN.
REQ-019 DELAY: counter loads latched delay on entry and decrements each cycle; exactly delay cycles are spent in DELAY before RETURN.
REQ-020 RETURN: assert rd_return_valid[ch] (with rd_rdata[ch] = latched data) or wr_return_valid[ch]; all other return valids are 0.
REQ-021 When the matching return_ready is seen in RETURN: go to IDLE, increment o_done_cnt (wraps modulo 2^32), and set the pointer to the granted index + 1 modulo 2CH.
REQ-022 Latency with zero delay and immediately ready downstream: grant (cycle 0), o_req_valid (cycle 1), rsp accepted (cycle 2 at the earliest), return valid (cycle 3).
REQ-023 rd_rdata for non-selected channels, and during states other than RETURN, is driven 0.
REQ-024 Addresses are passed unmodified, 64 bits.
REQ-025 Write strobes are passed unmodified, 64 bits.
REQ-026 A change of i_delay_cnt after grant does not affect the in-flight transaction.
REQ-027 A response with i_rsp_valid outside WAIT_RSP is ignored.
REQ-028 i_end_proc in any state: next cycle is IDLE, pointer=0, all valids and readies deasserted, o_done_cnt held; an in-flight downstream request is dropped without completion.
REQ-029 When i_end_proc and a return handshake occur in the same cycle, i_end_proc wins and o_done_cnt is not incremented.

Reset
REQ-030 afu_rst asserted asynchronously forces: state IDLE, pointer 0, counter 0, all latched fields 0, o_done_cnt 0.
REQ-031 During reset, every output valid and ready is 0 and all data outputs are 0.
REQ-032 Reset asserted mid-transaction aborts the transaction with no return pulse.
REQ-033 After reset deasserts, operation resumes on the first rising edge.

Verification
REQ-034 Single read, ch0, addr 0x1000, delay 0, rsp data 0xA5.. -> o_req_is_wr=0, o_req_addr=0x1000; rd_return_valid[0] at cycle 3 with rd_rdata[0]=0xA5..; o_done_cnt=1.
REQ-035 Write, ch1, wstrb all-ones, delay 10 -> o_req_is_wr=1, o_req_ch=1; wr_return_valid[1] exactly 10 cycles after the rsp handshake.
REQ-036 rd0, wr0, rd1, wr1 held valid continuously -> grant order rd0, wr0, rd1, wr1, rd0; no source starves.
REQ-037 i_req_ready held 0 for 5 cycles, then i_rsp_valid; return_ready held 0 for 3 cycles -> o_req fields stable throughout; return valid held 3 cycles; single o_done_cnt increment.
REQ-038 i_end_proc pulsed during DELAY -> IDLE next cycle; no return valid; pointer 0; the next request from rd0 is granted first.
REQ-039 afu_rst asserted between edges during ISSUE -> o_req_valid drops immediately; all counters 0.

Source files
------------

// File: rtl/nvme_req_arb.sv
// NVMe request arbiter: round-robin over per-channel read/write sources,
// single outstanding downstream transaction, emulated response latency.
module nvme_req_arb #(
  parameter int unsigned CH = 2,
  localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  afu_clk,
  input  logic                  afu_rst,
  input  logic                  i_end_proc,
  input  logic [63:0]           i_delay_cnt,
  // Read request / completion
  input  logic [CH-1:0]         rd_valid,
  input  logic [CH-1:0][63:0]   rd_araddr,
  output logic [CH-1:0]         rd_ready,
  output logic [CH-1:0]         rd_return_valid,
  output logic [CH-1:0][511:0]  rd_rdata,
  input  logic [CH-1:0]         rd_return_ready,
  // Write request / completion
  input  logic [CH-1:0]         wr_valid,
  input  logic [CH-1:0][63:0]   wr_awaddr,
  input  logic [CH-1:0][511:0]  wr_wdata,
  input  logic [CH-1:0][63:0]   wr_wstrb,
  output logic [CH-1:0]         wr_ready,
  output logic [CH-1:0]         wr_return_valid,
  input  logic [CH-1:0]         wr_return_ready,
  // Downstream request
  output logic                  o_req_valid,
  input  logic                  i_req_ready,
  output logic                  o_req_is_wr,
  output logic [63:0]           o_req_addr,
  output logic [511:0]          o_req_wdata,
  output logic [63:0]           o_req_wstrb,
  output logic [CHW-1:0]        o_req_ch,
  // Downstream response
  input  logic                  i_rsp_valid,
  output logic                  o_rsp_ready,
  input  logic [511:0]          i_rsp_rdata,
  output logic [31:0]           o_done_cnt
);

  localparam int unsigned NS = 2 * CH;
  localparam int unsigned PW = $clog2(NS);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitRsp, StDelay, StReturn} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  gnt_q, gnt_d;
  logic           is_wr_q, is_wr_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [63:0]    addr_q, addr_d;
  logic [511:0]   wdata_q, wdata_d;
  logic [63:0]    wstrb_q, wstrb_d;
  logic [63:0]    delay_q, delay_d;
  logic [63:0]    cnt_q, cnt_d;
  logic [511:0]   rdata_q, rdata_d;
  logic [31:0]    done_q, done_d;

  logic [NS-1:0]  src_valid;
  logic           sel_found;
  logic [PW-1:0]  sel_idx;
  logic [CHW-1:0] sel_ch;

  assign sel_ch = CHW'(sel_idx >> 1);

  // Round-robin pick: first valid source at or after the pointer, wrapping.
  always_comb begin
    src_valid = '0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int c = 0; c < int'(CH); c++) begin
      src_valid[2*c]   = rd_valid[c];
      src_valid[2*c+1] = wr_valid[c];
    end
    for (int k = 0; k < int'(NS); k++) begin
      if (!sel_found && src_valid[(int'(ptr_q) + k) % int'(NS)]) begin
        sel_found = 1'b1;
        sel_idx   = PW'((int'(ptr_q) + k) % int'(NS));
      end
    end
  end

  // Transaction FSM: next state, latched fields and handshake outputs.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    gnt_d           = gnt_q;
    is_wr_d         = is_wr_q;
    ch_d            = ch_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    delay_d         = delay_q;
    cnt_d           = cnt_q;
    rdata_d         = rdata_q;
    done_d          = done_q;
    rd_ready        = '0;
    wr_ready        = '0;
    o_req_valid     = 1'b0;
    o_rsp_ready     = 1'b0;
    rd_return_valid = '0;
    wr_return_valid = '0;
    rd_rdata        = '0;

    unique case (state_q)
      StIdle: begin
        // Reset gating keeps readies low while the reset is still asserted.
        if (sel_found && !afu_rst && !i_end_proc) begin
          gnt_d   = sel_idx;
          is_wr_d = sel_idx[0];
          ch_d    = sel_ch;
          delay_d = i_delay_cnt;
          if (sel_idx[0]) begin
            wr_ready[sel_ch] = 1'b1;
            addr_d           = wr_awaddr[sel_ch];
            wdata_d          = wr_wdata[sel_ch];
            wstrb_d          = wr_wstrb[sel_ch];
          end else begin
            rd_ready[sel_ch] = 1'b1;
            addr_d           = rd_araddr[sel_ch];
            wdata_d          = '0;
            wstrb_d          = '0;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        o_req_valid = 1'b1;
        if (i_req_ready) state_d = StWaitRsp;
      end
      StWaitRsp: begin
        o_rsp_ready = 1'b1;
        if (i_rsp_valid) begin
          if (!is_wr_q) rdata_d = i_rsp_rdata;
          cnt_d   = delay_q;
          state_d = (delay_q != 64'd0) ? StDelay : StReturn;
        end
      end
      StDelay: begin
        cnt_d = cnt_q - 64'd1;
        if (cnt_q == 64'd1) state_d = StReturn;
      end
      StReturn: begin
        if (is_wr_q) begin
          wr_return_valid[ch_q] = 1'b1;
        end else begin
          rd_return_valid[ch_q] = 1'b1;
          rd_rdata[ch_q]        = rdata_q;
        end
        if ((is_wr_q && wr_return_ready[ch_q]) || (!is_wr_q && rd_return_ready[ch_q])) begin
          state_d = StIdle;
          done_d  = done_q + 32'd1;
          ptr_d   = (gnt_q == PW'(NS - 1)) ? '0 : gnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a same-cycle return handshake.
    if (i_end_proc) begin
      state_d         = StIdle;
      ptr_d           = '0;
      cnt_d           = '0;
      done_d          = done_q;
      rd_ready        = '0;
      wr_ready        = '0;
      o_req_valid     = 1'b0;
      o_rsp_ready     = 1'b0;
      rd_return_valid = '0;
      wr_return_valid = '0;
      rd_rdata        = '0;
    end
  end

  assign o_req_is_wr = is_wr_q;
  assign o_req_addr  = addr_q;
  assign o_req_wdata = wdata_q;
  assign o_req_wstrb = wstrb_q;
  assign o_req_ch    = ch_q;
  assign o_done_cnt  = done_q;

  // State and latched-field registers.
  always_ff @(posedge afu_clk or posedge afu_rst) begin
    if (afu_rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      is_wr_q <= 1'b0;
      ch_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      delay_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      is_wr_q <= is_wr_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      delay_q <= delay_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_nvme_req_arb.sv
// Directed bench for nvme_req_arb with two channels.
module tb_nvme_req_arb;

  logic                 afu_clk, afu_rst, i_end_proc;
  logic [63:0]          i_delay_cnt;
  logic [1:0]           rd_valid, rd_ready, rd_return_valid, rd_return_ready;
  logic [1:0][63:0]     rd_araddr;
  logic [1:0][511:0]    rd_rdata;
  logic [1:0]           wr_valid, wr_ready, wr_return_valid, wr_return_ready;
  logic [1:0][63:0]     wr_awaddr, wr_wstrb;
  logic [1:0][511:0]    wr_wdata;
  logic                 o_req_valid, i_req_ready, o_req_is_wr, o_req_ch;
  logic [63:0]          o_req_addr, o_req_wstrb;
  logic [511:0]         o_req_wdata;
  logic                 i_rsp_valid, o_rsp_ready;
  logic [511:0]         i_rsp_rdata;
  logic [31:0]          o_done_cnt;

  int checks = 0;
  int errors = 0;

  nvme_req_arb #(.CH(2)) dut (
    .afu_clk(afu_clk), .afu_rst(afu_rst), .i_end_proc(i_end_proc), .i_delay_cnt(i_delay_cnt),
    .rd_valid(rd_valid), .rd_araddr(rd_araddr), .rd_ready(rd_ready),
    .rd_return_valid(rd_return_valid), .rd_rdata(rd_rdata), .rd_return_ready(rd_return_ready),
    .wr_valid(wr_valid), .wr_awaddr(wr_awaddr), .wr_wdata(wr_wdata), .wr_wstrb(wr_wstrb),
    .wr_ready(wr_ready), .wr_return_valid(wr_return_valid), .wr_return_ready(wr_return_ready),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_is_wr(o_req_is_wr),
    .o_req_addr(o_req_addr), .o_req_wdata(o_req_wdata), .o_req_wstrb(o_req_wstrb),
    .o_req_ch(o_req_ch), .i_rsp_valid(i_rsp_valid), .o_rsp_ready(o_rsp_ready),
    .i_rsp_rdata(i_rsp_rdata), .o_done_cnt(o_done_cnt)
  );

  initial afu_clk = 1'b0;
  always #5 afu_clk = ~afu_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge afu_clk);
    #1;
  endtask

  task automatic test_reset();
    afu_rst = 1'b1;
    rd_valid = 2'b11;
    wr_valid = 2'b11;
    @(negedge afu_clk);
    checks++;
    if ({wr_ready, rd_ready} !== 4'b0000 || o_req_valid !== 1'b0 || o_rsp_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshakes: got rdy=%b req_valid=%b rsp_ready=%b exp all 0",
               {wr_ready, rd_ready}, o_req_valid, o_rsp_ready);
    end
    checks++;
    if ({wr_return_valid, rd_return_valid} !== 4'b0 || rd_rdata !== '0 || o_req_addr !== 64'd0
        || o_done_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ret=%b addr=%h done=%0d exp 0",
               {wr_return_valid, rd_return_valid}, o_req_addr, o_done_cnt);
    end
    rd_valid = 2'b00;
    wr_valid = 2'b00;
    tick();
    afu_rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    rd_araddr[0] = 64'h1000;
    i_delay_cnt = 64'd0;
    i_req_ready = 1'b1;
    i_rsp_valid = 1'b1;  // held early: must be ignored until WAIT_RSP
    i_rsp_rdata = {64{8'hA5}};
    rd_return_ready = 2'b11;
    rd_valid = 2'b01;
    @(negedge afu_clk);
    checks++;
    if ({wr_ready, rd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL rd_grant: got %b exp 0001", {wr_ready, rd_ready});
    end
    tick();
    rd_valid = 2'b00;
    @(negedge afu_clk);
    checks++;
    if (o_req_valid !== 1'b1 || o_req_is_wr !== 1'b0 || o_req_addr !== 64'h1000 || o_req_ch !== 1'b0)
    begin
      errors++;
      $display("FAIL rd_issue: got v=%b wr=%b addr=%h ch=%b exp 1 0 1000 0",
               o_req_valid, o_req_is_wr, o_req_addr, o_req_ch);
    end
    tick();
    @(negedge afu_clk);
    checks++;
    if (o_rsp_ready !== 1'b1 || rd_return_valid !== 2'b00) begin
      errors++;
      $display("FAIL rd_wait: got rsp_ready=%b ret=%b exp 1 00", o_rsp_ready, rd_return_valid);
    end
    tick();
    @(negedge afu_clk);
    checks++;
    if (rd_return_valid !== 2'b01 || rd_rdata[0] !== {64{8'hA5}} || rd_rdata[1] !== 512'd0) begin
      errors++;
      $display("FAIL rd_return: got ret=%b d0=%h exp 01 a5..", rd_return_valid, rd_rdata[0]);
    end
    tick();
    @(negedge afu_clk);
    checks++;
    if (rd_return_valid !== 2'b00 || o_done_cnt !== 32'd1) begin
      errors++;
      $display("FAIL rd_done: got ret=%b done=%0d exp 00 1", rd_return_valid, o_done_cnt);
    end
    i_rsp_valid = 1'b0;
    tick();
  endtask

  task automatic test_write_delay();
    wr_awaddr[1] = 64'h0000_0000_abcd_0080;
    wr_wdata[1] = {16{32'h1234_5678}};
    wr_wstrb[1] = '1;
    i_delay_cnt = 64'd10;
    i_req_ready = 1'b1;
    i_rsp_valid = 1'b1;
    wr_return_ready = 2'b11;
    wr_valid = 2'b10;
    @(negedge afu_clk);
    checks++;
    if ({wr_ready, rd_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL wr_grant: got %b exp 1000", {wr_ready, rd_ready});
    end
    tick();
    wr_valid = 2'b00;
    i_delay_cnt = 64'd3;  // must not affect the in-flight write
    @(negedge afu_clk);
    checks++;
    if (o_req_valid !== 1'b1 || o_req_is_wr !== 1'b1 || o_req_ch !== 1'b1
        || o_req_addr !== 64'h0000_0000_abcd_0080 || o_req_wstrb !== {64{1'b1}}
        || o_req_wdata !== {16{32'h1234_5678}}) begin
      errors++;
      $display("FAIL wr_issue: got v=%b wr=%b ch=%b addr=%h strb=%h",
               o_req_valid, o_req_is_wr, o_req_ch, o_req_addr, o_req_wstrb);
    end
    tick();
    @(negedge afu_clk);
    checks++;
    if (o_rsp_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_wait: got rsp_ready=%b exp 1", o_rsp_ready);
    end
    tick();  // response handshake edge
    for (int i = 0; i < 10; i++) begin
      @(negedge afu_clk);
      checks++;
      if (wr_return_valid !== 2'b00) begin
        errors++;
        $display("FAIL wr_delay_early: cycle %0d got ret=%b exp 00", i, wr_return_valid);
      end
      tick();
    end
    @(negedge afu_clk);
    checks++;
    if (wr_return_valid !== 2'b10 || rd_return_valid !== 2'b00) begin
      errors++;
      $display("FAIL wr_return: got wr=%b rd=%b exp 10 00", wr_return_valid, rd_return_valid);
    end
    i_rsp_valid = 1'b0;
    tick();
    @(negedge afu_clk);
    checks++;
    if (o_done_cnt !== 32'd2) begin
      errors++;
      $display("FAIL wr_done: got %0d exp 2", o_done_cnt);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_gnt  [5] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b0001};
    logic [63:0] exp_addr [5] = '{64'h100, 64'h300, 64'h200, 64'h400, 64'h100};
    rd_araddr[0] = 64'h100;
    rd_araddr[1] = 64'h200;
    wr_awaddr[0] = 64'h300;
    wr_awaddr[1] = 64'h400;
    i_delay_cnt = 64'd0;
    i_req_ready = 1'b1;
    i_rsp_valid = 1'b1;
    rd_return_ready = 2'b11;
    wr_return_ready = 2'b11;
    rd_valid = 2'b11;
    wr_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge afu_clk);
      checks++;
      if ({wr_ready, rd_ready} !== exp_gnt[i]) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b exp %b", i, {wr_ready, rd_ready}, exp_gnt[i]);
      end
      tick();
      @(negedge afu_clk);
      checks++;
      if (o_req_addr !== exp_addr[i]) begin
        errors++;
        $display("FAIL rr_addr[%0d]: got %h exp %h", i, o_req_addr, exp_addr[i]);
      end
      tick();
      tick();
      tick();
    end
    rd_valid = 2'b00;
    wr_valid = 2'b00;
    i_rsp_valid = 1'b0;
    @(negedge afu_clk);
    checks++;
    if (o_done_cnt !== 32'd7) begin
      errors++;
      $display("FAIL rr_done: got %0d exp 7", o_done_cnt);
    end
    tick();
  endtask

  task automatic test_stall();
    rd_araddr[1] = 64'hdead_beef_0000_0040;
    i_delay_cnt = 64'd0;
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    rd_return_ready = 2'b00;
    rd_valid = 2'b10;
    @(negedge afu_clk);
    checks++;
    if ({wr_ready, rd_ready} !== 4'b0010) begin
      errors++;
      $display("FAIL stall_grant: got %b exp 0010", {wr_ready, rd_ready});
    end
    tick();
    rd_valid = 2'b00;
    rd_araddr[1] = 64'h0;  // latched copy must stay put
    for (int i = 0; i < 5; i++) begin
      @(negedge afu_clk);
      checks++;
      if (o_req_valid !== 1'b1 || o_req_addr !== 64'hdead_beef_0000_0040 || o_req_ch !== 1'b1
          || o_req_is_wr !== 1'b0) begin
        errors++;
        $display("FAIL stall_issue[%0d]: got v=%b addr=%h ch=%b exp 1 deadbeef00000040 1",
                 i, o_req_valid, o_req_addr, o_req_ch);
      end
      tick();
    end
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b1;
    i_rsp_rdata = {64{8'h3c}};
    @(negedge afu_clk);
    checks++;
    if (o_rsp_ready !== 1'b1 || o_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_wait: got rsp_ready=%b req_valid=%b exp 1 0", o_rsp_ready, o_req_valid);
    end
    tick();
    i_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge afu_clk);
      checks++;
      if (rd_return_valid !== 2'b10 || o_done_cnt !== 32'd7) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got ret=%b done=%0d exp 10 7", i, rd_return_valid, o_done_cnt);
      end
      tick();
    end
    rd_return_ready = 2'b10;
    @(negedge afu_clk);
    checks++;
    if (rd_rdata[1] !== {64{8'h3c}} || rd_rdata[0] !== 512'd0) begin
      errors++;
      $display("FAIL stall_data: got %h exp 3c..", rd_rdata[1]);
    end
    tick();
    @(negedge afu_clk);
    checks++;
    if (o_done_cnt !== 32'd8 || rd_return_valid !== 2'b00) begin
      errors++;
      $display("FAIL stall_done: got done=%0d ret=%b exp 8 00", o_done_cnt, rd_return_valid);
    end
    tick();
  endtask

  task automatic test_end_proc();
    // Pointer is 3 here; rd1 is the only requester.
    rd_araddr[1] = 64'h7000;
    i_delay_cnt = 64'd5;
    i_req_ready = 1'b1;
    i_rsp_valid = 1'b1;
    rd_return_ready = 2'b11;
    wr_return_ready = 2'b11;
    rd_valid = 2'b10;
    @(negedge afu_clk);
    checks++;
    if ({wr_ready, rd_ready} !== 4'b0010) begin
      errors++;
      $display("FAIL ep_grant: got %b exp 0010", {wr_ready, rd_ready});
    end
    tick();
    rd_valid = 2'b00;
    tick();
    tick();
    tick();  // second DELAY cycle
    i_end_proc = 1'b1;
    i_rsp_valid = 1'b0;
    @(negedge afu_clk);
    checks++;
    if ({wr_return_valid, rd_return_valid} !== 4'b0) begin
      errors++;
      $display("FAIL ep_no_return: got %b exp 0000", {wr_return_valid, rd_return_valid});
    end
    tick();
    i_end_proc = 1'b0;
    rd_araddr[0] = 64'h5000;
    rd_valid = 2'b01;
    wr_valid = 2'b10;  // would win if the pointer had stayed at 3
    @(negedge afu_clk);
    checks++;
    if ({wr_ready, rd_ready} !== 4'b0001 || o_req_valid !== 1'b0 || o_done_cnt !== 32'd8) begin
      errors++;
      $display("FAIL ep_regrant: got rdy=%b req_valid=%b done=%0d exp 0001 0 8",
               {wr_ready, rd_ready}, o_req_valid, o_done_cnt);
    end
    tick();
    rd_valid = 2'b00;
    wr_valid = 2'b00;
  endtask

  task automatic test_reset_issue();
    i_req_ready = 1'b0;
    @(negedge afu_clk);
    checks++;
    if (o_req_valid !== 1'b1 || o_req_addr !== 64'h5000) begin
      errors++;
      $display("FAIL ri_issue: got v=%b addr=%h exp 1 5000", o_req_valid, o_req_addr);
    end
    #2;
    afu_rst = 1'b1;
    #1;
    checks++;
    if (o_req_valid !== 1'b0 || o_req_addr !== 64'd0 || o_done_cnt !== 32'd0) begin
      errors++;
      $display("FAIL ri_async: got v=%b addr=%h done=%0d exp 0 0 0",
               o_req_valid, o_req_addr, o_done_cnt);
    end
    tick();
    afu_rst = 1'b0;
    rd_araddr[0] = 64'h6000;
    rd_valid = 2'b01;
    @(negedge afu_clk);
    checks++;
    if (rd_ready !== 2'b01 || rd_return_valid !== 2'b00) begin
      errors++;
      $display("FAIL ri_resume_grant: got rdy=%b ret=%b exp 01 00", rd_ready, rd_return_valid);
    end
    tick();
    rd_valid = 2'b00;
    @(negedge afu_clk);
    checks++;
    if (o_req_valid !== 1'b1 || o_req_addr !== 64'h6000) begin
      errors++;
      $display("FAIL ri_resume_issue: got v=%b addr=%h exp 1 6000", o_req_valid, o_req_addr);
    end
    tick();
  endtask

  initial begin
    afu_rst = 1'b0;
    i_end_proc = 1'b0;
    i_delay_cnt = '0;
    rd_valid = '0;
    rd_araddr = '0;
    rd_return_ready = '0;
    wr_valid = '0;
    wr_awaddr = '0;
    wr_wdata = '0;
    wr_wstrb = '0;
    wr_return_ready = '0;
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_rdata = '0;
    #3;
    test_reset();
    test_single_read();
    test_write_delay();
    test_round_robin();
    test_stall();
    test_end_proc();
    test_reset_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
